instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control FSM.
- Owns PC and the Instruction Register, issues instruction reads to a fixed-latency memory, and captures the returned word into IR.
- Presents Op/Funct/fields to the control FSM and applies the control FSM's PC-update commands.
- Replaces the control FSM's DELAY1/DELAY2 wait states with an explicit fetch handshake.

Parameters:
- MEM_LATENCY, 2, cycles from MemRead/MemAddr presented to MemData valid; legal range 1..7.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- FetchReq  in  1  control FSM requests an instruction fetch at the current PC.
- PCWrite  in  1  unconditional PC load.
- PCWriteCond  in  1  PC load qualified by Zero.
- Zero  in  1  ALU zero flag.
- PCSource  in  2  next-PC select: 0 = ALUResult, 1 = ALUOut, 2 = jump target, 3 = hold.
- ALUResult  in  32  combinational ALU result (PC+4).
- ALUOut  in  32  registered ALU result (branch target).
- MemData  in  32  memory read data.
- MemAddr  out  32  instruction address to memory.
- MemRead  out  1  memory read strobe.
- Instr  out  32  IR contents.
- Op  out  6  Instr[31:26].
- Funct  out  6  Instr[5:0].
- Rs, Rt, Rd  out  5 each  Instr[25:21], [20:16], [15:11].
- Imm16  out  16  Instr[15:0].
- PC  out  32  current PC.
- InstrValid  out  1  one-cycle pulse when IR has just been loaded.
- Busy  out  1  high while a fetch is in flight.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - State = IDLE, PC = RESET_PC, Instr = 0 (NOP).
  - MemRead = 0, MemAddr = 0, InstrValid = 0, Busy = 0, latency counter = 0.
- State machine: IDLE, WAIT, LOAD.
- IDLE:
  - FetchReq = 1 -> latch PC into MemAddr, MemRead = 1, counter = 1, go to WAIT, Busy = 1.
  - FetchReq = 0 -> stay in IDLE.
- WAIT:
  - MemRead held at 1 and MemAddr held stable.
  - Counter increments each cycle.
  - When counter == MEM_LATENCY: Instr <= MemData, MemRead = 0, go to LOAD.
- LOAD: InstrValid = 1 for exactly this one cycle, Busy = 0, then return to IDLE.
- Latency: FetchReq sampled at edge N -> IR updated at edge N+MEM_LATENCY -> InstrValid high in the following cycle. A new FetchReq is accepted in IDLE only, so back-to-back throughput is one fetch per MEM_LATENCY+2 cycles.
- FetchReq while Busy or in LOAD: ignored, not queued.
- PC update, independent of fetch state:
  - PC <= next-PC when PCWrite | (PCWriteCond & Zero).
  - Jump target = {PC[31:28], Instr[25:0], 2'b00}.
  - PCSource = 3 -> PC holds even when a write is enabled.
- PC write during WAIT: PC updates, but the in-flight fetch completes with the previously latched MemAddr.
- Simultaneous PC write and FetchReq in IDLE: fetch uses the pre-update PC (value before the edge).
- Op/Funct/Rs/Rt/Rd/Imm16 are combinational slices of Instr. They are stable between loads and change only on the IR-load edge.
- Reset mid-fetch: the fetch is aborted immediately, no InstrValid pulse, and all reset values apply.
- Widths: PC arithmetic is external; no overflow handling; PC wraps naturally if the ALU wraps.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output AddrErr (1 bit, reset 0).
  - FetchReq in IDLE with PC[1:0] != 0 -> no memory read is issued; go directly to LOAD with Instr <= 0, InstrValid = 1 and AddrErr = 1 for that same cycle.
  - AddrErr is 0 at all other times.
- Undefined:
  - No AddrErr port.
  - MemAddr[1:0] forced to 2'b00; the fetch proceeds normally.

Decomposition:
- Shared package mips_pkg holds:
  - opcode enum (R-type 6'h00, BEQ 6'h04, BNE 6'h05, LUI 6'h0f, LW 6'h23, SW 6'h2b);
  - funct enum (ADD 6'h20, SUB 6'h22, AND 6'h24, XOR 6'h26, BREAK 6'h0d, NOP 6'h00);
  - pc_source_t enum (ALU_RES, ALU_OUT, JUMP, HOLD);
  - fetch_state_t enum (IDLE, WAIT, LOAD).
- The control FSM imports the same package.
- One sub-module, pc_unit: PC register, next-PC mux and write qualification. It is instantiated once inside instr_fetch_unit.

Test Plan:
- Reset release, MEM_LATENCY = 2, memory returns 32'h2009_0005 at address 0:
  - FetchReq pulse -> MemRead high for 2 cycles, MemAddr = 0.
  - Instr = 32'h2009_0005, Op = 6'h08, Rt = 9, Imm16 = 16'h0005; InstrValid is a single pulse 3 cycles after FetchReq.
- PC = 0x10, PCWrite = 1, PCSource = 0, ALUResult = 0x14 -> PC = 0x14 next cycle. Same inputs with PCSource = 3 -> PC stays 0x10.
- PCWriteCond = 1 with ALUOut = 0x40:
  - Zero = 0 -> PC unchanged.
  - Zero = 1 -> PC = 0x40.
  - PCSource = 2 with Instr = 32'h0800_0010 -> PC = 0x40.
- FetchReq at PC = 0x8, then PCWrite to 0x100 during WAIT and a second FetchReq during WAIT -> memory sees 0x8 only, exactly one InstrValid; the next fetch in IDLE uses 0x100.
- Reset_n asserted mid-WAIT -> MemRead = 0, Instr = 0, PC = RESET_PC in the same cycle, no InstrValid.
- With FETCH_MISALIGN_TRAP_EN defined, PC = 0x6 and FetchReq -> no MemRead; AddrErr = 1 and InstrValid = 1 one cycle later; Instr = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode types used by the fetch unit and the multicycle control FSM.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        FN_NOP   = 6'h00,
        FN_BREAK = 6'h0d,
        FN_ADD   = 6'h20,
        FN_SUB   = 6'h22,
        FN_AND   = 6'h24,
        FN_XOR   = 6'h26
    } funct_t;

    typedef enum logic [1:0] {
        ALU_RES = 2'd0,
        ALU_OUT = 2'd1,
        JUMP    = 2'd2,
        HOLD    = 2'd3
    } pc_source_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

    localparam int unsigned LAT_CNT_W = 3;

    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [25:0] index);
        return {pc[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC select and write qualification.
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        Zero,
    input  pc_source_t  PCSource,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [25:0] JumpIndex,
    output logic [31:0] PC
);

    logic        pc_load;
    logic [31:0] next_pc;

    always_comb begin
        next_pc = PC;
        case (PCSource)
            ALU_RES: next_pc = ALUResult;
            ALU_OUT: next_pc = ALUOut;
            JUMP:    next_pc = jump_target(PC, JumpIndex);
            default: next_pc = PC;
        endcase
    end

    // HOLD wins over any write enable so the control FSM can park the PC.
    assign pc_load = (PCWrite | (PCWriteCond & Zero)) & (PCSource != HOLD);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC <= RESET_PC;
        end else if (pc_load) begin
            PC <= next_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC and IR, runs a fixed-latency fetch handshake.
// Optional misaligned-fetch trap enabled by FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no fetch in flight, FetchReq accepted here only
// WAIT  | read issued, counting memory latency
// LOAD  | IR just loaded, InstrValid pulse
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        FetchReq,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        Zero,
    input  logic [1:0]  PCSource,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemData,
    output logic [31:0] MemAddr,
    output logic        MemRead,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm16,
    output logic [31:0] PC,
    output logic        InstrValid,
    output logic        Busy
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        AddrErr
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(MEM_LATENCY);

    fetch_state_t         state, state_nxt;
    logic [LAT_CNT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic                 addr_load, ir_load, ir_clear, trap;
    logic                 misaligned;
    logic [31:0]          fetch_addr;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .Zero        (Zero),
        .PCSource    (pc_source_t'(PCSource)),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .JumpIndex   (Instr[25:0]),
        .PC          (PC)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (PC[1:0] != 2'b00);
    assign fetch_addr = PC;
`else
    assign misaligned = 1'b0;
    assign fetch_addr = {PC[31:2], 2'b00};
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        addr_load   = 1'b0;
        ir_load     = 1'b0;
        ir_clear    = 1'b0;
        trap        = 1'b0;
        case (state)
            IDLE: begin
                if (FetchReq) begin
                    if (misaligned) begin
                        state_nxt = LOAD;
                        ir_clear  = 1'b1;
                        trap      = 1'b1;
                    end else begin
                        state_nxt   = WAIT;
                        addr_load   = 1'b1;
                        lat_cnt_nxt = LAT_CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == LAT) begin
                    state_nxt   = LOAD;
                    ir_load     = 1'b1;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + LAT_CNT_W'(1);
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign MemRead    = (state == WAIT);
    assign Busy       = (state == WAIT);
    assign InstrValid = (state == LOAD);

    // MemAddr is only loaded on acceptance, so PC writes during WAIT never disturb the read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_cnt <= '0;
            MemAddr <= '0;
            Instr   <= '0;
        end else begin
            lat_cnt <= lat_cnt_nxt;
            if (addr_load) begin
                MemAddr <= fetch_addr;
            end
            if (ir_load) begin
                Instr <= MemData;
            end else if (ir_clear) begin
                Instr <= '0;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            AddrErr <= 1'b0;
        end else begin
            AddrErr <= trap;
        end
    end
`endif

    assign Op    = Instr[31:26];
    assign Rs    = Instr[25:21];
    assign Rt    = Instr[20:16];
    assign Rd    = Instr[15:11];
    assign Imm16 = Instr[15:0];
    assign Funct = Instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        FetchReq, PCWrite, PCWriteCond, Zero;
    logic [1:0]  PCSource;
    logic [31:0] ALUResult, ALUOut, MemData, MemAddr, Instr, PC;
    logic        MemRead, InstrValid, Busy;
    logic [5:0]  Op, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm16;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        AddrErr;
`endif

    logic [31:0] mem [0:127];
    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    always #5 Clk = ~Clk;

    assign MemData = mem[MemAddr[8:2]];

    instr_fetch_unit #(
        .MEM_LATENCY (2),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .FetchReq    (FetchReq),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .Zero        (Zero),
        .PCSource    (PCSource),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .MemData     (MemData),
        .MemAddr     (MemAddr),
        .MemRead     (MemRead),
        .Instr       (Instr),
        .Op          (Op),
        .Funct       (Funct),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
        .Imm16       (Imm16),
        .PC          (PC),
        .InstrValid  (InstrValid),
        .Busy        (Busy)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .AddrErr     (AddrErr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] val);
        PCWrite   = 1'b1;
        PCSource  = 2'd0;
        ALUResult = val;
        tick();
        PCWrite   = 1'b0;
    endtask

    // Issue one fetch and leave the DUT back in IDLE.
    task automatic fetch();
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2009_0005;
        mem[1]  = 32'h1234_0004;
        mem[2]  = 32'hAAAA_0001;
        mem[8]  = 32'h0800_0010;
        mem[64] = 32'h0123_4567;

        Reset_n = 1'b0; FetchReq = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0;
        Zero = 1'b0; PCSource = 2'd0; ALUResult = '0; ALUOut = '0;
        #12;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_memread", {31'b0, MemRead}, 32'h0);
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        Reset_n = 1'b1;
        tick();

        // Basic fetch at address 0
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
        chk("f0_memread1", {31'b0, MemRead}, 32'h1);
        chk("f0_memaddr", MemAddr, 32'h0);
        chk("f0_busy", {31'b0, Busy}, 32'h1);
        chk("f0_valid_c1", {31'b0, InstrValid}, 32'h0);
        tick();
        chk("f0_memread2", {31'b0, MemRead}, 32'h1);
        chk("f0_valid_c2", {31'b0, InstrValid}, 32'h0);
        tick();
        chk("f0_memread3", {31'b0, MemRead}, 32'h0);
        chk("f0_valid_c3", {31'b0, InstrValid}, 32'h1);
        chk("f0_busy_load", {31'b0, Busy}, 32'h0);
        chk("f0_instr", Instr, 32'h2009_0005);
        chk("f0_op", {26'b0, Op}, 32'h08);
        chk("f0_rs", {27'b0, Rs}, 32'h0);
        chk("f0_rt", {27'b0, Rt}, 32'h9);
        chk("f0_imm", {16'b0, Imm16}, 32'h5);
        tick();
        chk("f0_valid_c4", {31'b0, InstrValid}, 32'h0);

        // PC writes and HOLD
        set_pc(32'h10);
        chk("pc_set10", PC, 32'h10);
        set_pc(32'h14);
        chk("pc_alures", PC, 32'h14);
        set_pc(32'h10);
        PCWrite = 1'b1; PCSource = 2'd3; ALUResult = 32'h14;
        tick();
        PCWrite = 1'b0;
        chk("pc_hold", PC, 32'h10);

        // Conditional write on Zero
        PCWriteCond = 1'b1; PCSource = 2'd1; ALUOut = 32'h40; Zero = 1'b0;
        tick();
        chk("pc_cond_z0", PC, 32'h10);
        Zero = 1'b1;
        tick();
        chk("pc_cond_z1", PC, 32'h40);
        PCWriteCond = 1'b0; Zero = 1'b0;

        // Jump target from fetched instruction
        set_pc(32'h20);
        fetch();
        chk("j_instr", Instr, 32'h0800_0010);
        chk("j_op", {26'b0, Op}, 32'h02);
        PCWrite = 1'b1; PCSource = 2'd2;
        tick();
        PCWrite = 1'b0; PCSource = 2'd0;
        chk("pc_jump", PC, 32'h40);

        // PC write and ignored FetchReq during WAIT
        set_pc(32'h8);
        FetchReq = 1'b1;
        tick();
        chk("w_memaddr1", MemAddr, 32'h8);
        chk("w_memread1", {31'b0, MemRead}, 32'h1);
        PCWrite = 1'b1; ALUResult = 32'h100;
        tick();
        FetchReq = 1'b0; PCWrite = 1'b0;
        chk("w_pc_upd", PC, 32'h100);
        chk("w_memaddr2", MemAddr, 32'h8);
        tick();
        chk("w_valid", {31'b0, InstrValid}, 32'h1);
        chk("w_instr", Instr, 32'hAAAA_0001);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (InstrValid) pulses++;
            if (MemRead) pulses++;
        end
        chk("w_no_extra", pulses, 0);

        // FetchReq and PC write on the same edge: fetch uses the old PC
        FetchReq = 1'b1; PCWrite = 1'b1; ALUResult = 32'h4;
        tick();
        FetchReq = 1'b0; PCWrite = 1'b0;
        chk("s_memaddr", MemAddr, 32'h100);
        chk("s_pc", PC, 32'h4);
        tick();
        tick();
        chk("s_instr", Instr, 32'h0123_4567);
        tick();

        // Reset mid-WAIT
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("r_memread", {31'b0, MemRead}, 32'h0);
        chk("r_instr", Instr, 32'h0);
        chk("r_pc", PC, 32'h0);
        chk("r_busy", {31'b0, Busy}, 32'h0);
        chk("r_valid", {31'b0, InstrValid}, 32'h0);
        #2;
        Reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (InstrValid) pulses++;
        end
        chk("r_no_valid", pulses, 0);

        // Misaligned PC
        set_pc(32'h6);
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("m_memread", {31'b0, MemRead}, 32'h0);
        chk("m_valid", {31'b0, InstrValid}, 32'h1);
        chk("m_addrerr", {31'b0, AddrErr}, 32'h1);
        chk("m_instr", Instr, 32'h0);
        tick();
        chk("m_addrerr_clr", {31'b0, AddrErr}, 32'h0);
        chk("m_valid_clr", {31'b0, InstrValid}, 32'h0);
`else
        chk("m_memread", {31'b0, MemRead}, 32'h1);
        chk("m_memaddr", MemAddr, 32'h4);
        tick();
        tick();
        chk("m_valid", {31'b0, InstrValid}, 32'h1);
        chk("m_instr", Instr, 32'h1234_0004);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
